// File: rtl/vote_session_ctrl.sv
// rtl/vote_session_ctrl.sv - 4-voter session sequencer with registered 3-of-4 majority decision
// Optional collect timeout enabled by defining VOTE_SESSION_TIMEOUT_EN.
module vote_session_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned THRESHOLD      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] vote_valid,
  input  logic [3:0] vote_val,
  output logic       busy,
  output logic [3:0] voted_mask,
  output logic       result_valid,
  output logic       result,
  output logic       timed_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DECIDE,
    S_DONE
  } state_t;

  localparam logic [2:0] THRESH = 3'(THRESHOLD);

  state_t     state_q, state_d;
  logic [3:0] mask_q, mask_d;
  logic [3:0] votes_q, votes_d;
  logic       result_q, result_d;
  logic       timed_out_q, timed_out_d;
  logic [3:0] accept;
  logic [3:0] counted;
  logic [2:0] popcount;
  logic       timer_expired;

`ifdef VOTE_SESSION_TIMEOUT_EN
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] timer_q, timer_d;

  assign timer_expired = (timer_q == TIMER_LAST);

  always_comb begin
    timer_d = timer_q;
    if (state_q == S_IDLE && start) begin
      timer_d = 8'd0;
    end else if (state_q == S_COLLECT) begin
      timer_d = timer_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= 8'd0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  logic unused_timeout_cycles;

  assign timer_expired         = 1'b0;
  assign unused_timeout_cycles = ^32'(TIMEOUT_CYCLES);
`endif

  // Only latched votes contribute; unvoted voters count as 0.
  assign counted  = votes_q & mask_q;
  assign popcount = {2'b00, counted[0]} + {2'b00, counted[1]}
                  + {2'b00, counted[2]} + {2'b00, counted[3]};
  assign accept   = vote_valid & ~mask_q;

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    votes_d     = votes_q;
    result_d    = result_q;
    timed_out_d = timed_out_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_COLLECT;
          mask_d  = 4'b0000;
          votes_d = 4'b0000;
        end
      end
      S_COLLECT: begin
        mask_d  = mask_q | accept;
        votes_d = (votes_q & ~accept) | (vote_val & accept);
        // Full mask is checked first so a coincident expiry is not a timeout.
        if (mask_d == 4'b1111 || timer_expired) begin
          state_d = S_DECIDE;
        end
      end
      S_DECIDE: begin
        result_d    = (popcount >= THRESH);
`ifdef VOTE_SESSION_TIMEOUT_EN
        timed_out_d = (mask_q != 4'b1111);
`else
        timed_out_d = 1'b0;
`endif
        state_d     = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mask_q      <= 4'b0000;
      votes_q     <= 4'b0000;
      result_q    <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      votes_q     <= votes_d;
      result_q    <= result_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign busy         = (state_q == S_COLLECT) || (state_q == S_DECIDE);
  assign voted_mask   = mask_q;
  assign result_valid = (state_q == S_DONE);
  assign result       = result_q;
  assign timed_out    = timed_out_q;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// tb/tb_vote_session_ctrl.sv - directed self-checking bench for vote_session_ctrl
// Timeout scenarios run when VOTE_SESSION_TIMEOUT_EN is defined; otherwise the no-timer wait scenario runs.
module tb_vote_session_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] vote_valid;
  logic [3:0] vote_val;
  logic       busy;
  logic [3:0] voted_mask;
  logic       result_valid;
  logic       result;
  logic       timed_out;

  int n_vec;
  int n_err;

  vote_session_ctrl #(
    .TIMEOUT_CYCLES(16),
    .THRESHOLD(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .vote_valid(vote_valid),
    .vote_val(vote_val),
    .busy(busy),
    .voted_mask(voted_mask),
    .result_valid(result_valid),
    .result(result),
    .timed_out(timed_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; vote_valid = 4'b0; vote_val = 4'b0;
    tick();
    tick();
    n_vec++;
    if ({busy, voted_mask, result_valid, result, timed_out} !== 8'b0) begin
      $display("FAIL reset_outputs: got %b want %b", {busy, voted_mask, result_valid, result, timed_out}, 8'b0);
      n_err++;
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if (busy !== 1'b0) begin
      $display("FAIL reset_idle_busy: got %b want 0", busy);
      n_err++;
    end
  endtask

  // Votes 1101 all in the first COLLECT cycle; result_valid 3 edges after the start edge.
  task automatic test_fast_path();
    start = 1'b1;
    tick();
    start = 1'b0; vote_valid = 4'b1111; vote_val = 4'b1101;
    n_vec++;
    if (busy !== 1'b1) begin
      $display("FAIL fast_busy_collect: got %b want 1", busy);
      n_err++;
    end
    tick();
    vote_valid = 4'b0; vote_val = 4'b0;
    n_vec++;
    if ({busy, result_valid, voted_mask} !== 6'b10_1111) begin
      $display("FAIL fast_decide: got %b want %b", {busy, result_valid, voted_mask}, 6'b10_1111);
      n_err++;
    end
    tick();
    n_vec++;
    if ({result_valid, result, timed_out, busy} !== 4'b1100) begin
      $display("FAIL fast_done: got %b want %b", {result_valid, result, timed_out, busy}, 4'b1100);
      n_err++;
    end
    tick();
    n_vec++;
    if ({result_valid, result} !== 2'b01) begin
      $display("FAIL fast_hold: got %b want %b", {result_valid, result}, 2'b01);
      n_err++;
    end
  endtask

  // voter0=1 then re-strobes 0; voters 1,2,3 vote 0,1,0 -> latched 0101, count 2 -> result 0.
  task automatic test_staggered_repeat();
    start = 1'b1;
    tick();
    start = 1'b0; vote_valid = 4'b0001; vote_val = 4'b0001;
    tick();
    vote_valid = 4'b0001; vote_val = 4'b0000;
    tick();
    n_vec++;
    if ({busy, voted_mask} !== 5'b1_0001) begin
      $display("FAIL stagger_mask: got %b want %b", {busy, voted_mask}, 5'b1_0001);
      n_err++;
    end
    vote_valid = 4'b1110; vote_val = 4'b0100;
    tick();
    vote_valid = 4'b0; vote_val = 4'b0;
    tick();
    n_vec++;
    if ({result_valid, result, timed_out, voted_mask} !== 7'b100_1111) begin
      $display("FAIL stagger_done: got %b want %b", {result_valid, result, timed_out, voted_mask}, 7'b100_1111);
      n_err++;
    end
    tick();
  endtask

  // start held through DONE must not open a new session once IDLE is reached with start low.
  task automatic test_start_in_done();
    start = 1'b1;
    tick();
    start = 1'b0; vote_valid = 4'b1111; vote_val = 4'b0111;
    tick();
    vote_valid = 4'b0;
    tick();
    start = 1'b1;
    n_vec++;
    if ({result_valid, result} !== 2'b11) begin
      $display("FAIL done_result: got %b want %b", {result_valid, result}, 2'b11);
      n_err++;
    end
    tick();
    start = 1'b0;
    tick();
    n_vec++;
    if (busy !== 1'b0) begin
      $display("FAIL start_in_done_ignored: busy got %b want 0", busy);
      n_err++;
    end
  endtask

  // Two sessions at the minimum 4-cycle period, second one flips the result.
  task automatic test_back_to_back();
    for (int s = 0; s < 2; s++) begin
      start = 1'b1;
      tick();
      start = 1'b0; vote_valid = 4'b1111; vote_val = (s == 0) ? 4'b1011 : 4'b0011;
      tick();
      vote_valid = 4'b0;
      tick();
      n_vec++;
      if ({result_valid, result} !== {1'b1, (s == 0)}) begin
        $display("FAIL b2b_session%0d: got %b want %b", s, {result_valid, result}, {1'b1, (s == 0)});
        n_err++;
      end
      tick();
    end
  endtask

  // Reset mid-COLLECT with mask 0011, after a session left result=1.
  task automatic test_reset_mid_collect();
    start = 1'b1;
    tick();
    start = 1'b0; vote_valid = 4'b1111; vote_val = 4'b1111;
    tick();
    vote_valid = 4'b0;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0; vote_valid = 4'b0011; vote_val = 4'b0011;
    tick();
    vote_valid = 4'b0;
    n_vec++;
    if ({busy, voted_mask, result} !== 6'b1_0011_1) begin
      $display("FAIL midreset_pre: got %b want %b", {busy, voted_mask, result}, 6'b1_0011_1);
      n_err++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if ({busy, voted_mask, result_valid, result, timed_out} !== 8'b0) begin
      $display("FAIL midreset_outputs: got %b want %b", {busy, voted_mask, result_valid, result, timed_out}, 8'b0);
      n_err++;
    end
    start = 1'b1;
    tick();
    start = 1'b0; vote_valid = 4'b1111; vote_val = 4'b1100;
    tick();
    vote_valid = 4'b0;
    tick();
    n_vec++;
    if ({result_valid, result, timed_out} !== 3'b100) begin
      $display("FAIL midreset_fresh: got %b want %b", {result_valid, result, timed_out}, 3'b100);
      n_err++;
    end
    tick();
  endtask

`ifdef VOTE_SESSION_TIMEOUT_EN
  // Voters 1..3 vote 1; close at edge 17, result_valid at edge 18 counting the start edge.
  task automatic test_timeout();
    start = 1'b1;
    tick();
    start = 1'b0; vote_valid = 4'b1110; vote_val = 4'b1110;
    tick();
    vote_valid = 4'b0; vote_val = 4'b0;
    for (int e = 3; e <= 17; e++) tick();
    n_vec++;
    if ({busy, result_valid} !== 2'b10) begin
      $display("FAIL timeout_edge17: got %b want %b", {busy, result_valid}, 2'b10);
      n_err++;
    end
    tick();
    n_vec++;
    if ({result_valid, result, timed_out, voted_mask} !== 7'b111_1110) begin
      $display("FAIL timeout_done: got %b want %b", {result_valid, result, timed_out, voted_mask}, 7'b111_1110);
      n_err++;
    end
    tick();
  endtask

  // Fourth vote lands in the timer==15 cycle: full-mask exit wins.
  task automatic test_simultaneous();
    start = 1'b1;
    tick();
    start = 1'b0; vote_valid = 4'b1110; vote_val = 4'b0110;
    tick();
    vote_valid = 4'b0; vote_val = 4'b0;
    for (int e = 3; e <= 16; e++) tick();
    n_vec++;
    if ({busy, voted_mask} !== 5'b1_1110) begin
      $display("FAIL simul_edge16: got %b want %b", {busy, voted_mask}, 5'b1_1110);
      n_err++;
    end
    vote_valid = 4'b0001; vote_val = 4'b0001;
    tick();
    vote_valid = 4'b0; vote_val = 4'b0;
    tick();
    n_vec++;
    if ({result_valid, result, timed_out, voted_mask} !== 7'b110_1111) begin
      $display("FAIL simul_done: got %b want %b", {result_valid, result, timed_out, voted_mask}, 7'b110_1111);
      n_err++;
    end
    tick();
  endtask
`else
  // Without the timer, COLLECT waits for the fourth vote indefinitely.
  task automatic test_no_timeout();
    int stray_valid;
    int idle_busy;
    stray_valid = 0;
    idle_busy   = 0;
    start = 1'b1;
    tick();
    start = 1'b0; vote_valid = 4'b0111; vote_val = 4'b0111;
    tick();
    vote_valid = 4'b0; vote_val = 4'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (result_valid !== 1'b0) stray_valid++;
      if (busy !== 1'b1) idle_busy++;
    end
    n_vec++;
    if (stray_valid !== 0) begin
      $display("FAIL wait_no_result_valid: got %0d pulses want 0", stray_valid);
      n_err++;
    end
    n_vec++;
    if (idle_busy !== 0) begin
      $display("FAIL wait_busy_held: got %0d low cycles want 0", idle_busy);
      n_err++;
    end
    vote_valid = 4'b1000; vote_val = 4'b0000;
    tick();
    vote_valid = 4'b0;
    n_vec++;
    if ({busy, result_valid} !== 2'b10) begin
      $display("FAIL wait_decide: got %b want %b", {busy, result_valid}, 2'b10);
      n_err++;
    end
    tick();
    n_vec++;
    if ({result_valid, result, timed_out, voted_mask} !== 7'b110_1111) begin
      $display("FAIL wait_done: got %b want %b", {result_valid, result, timed_out, voted_mask}, 7'b110_1111);
      n_err++;
    end
    tick();
  endtask
`endif

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_fast_path();
    test_staggered_repeat();
    test_start_in_done();
    test_back_to_back();
    test_reset_mid_collect();
`ifdef VOTE_SESSION_TIMEOUT_EN
    test_timeout();
    test_simultaneous();
`else
    test_no_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
